// File: rtl/ball_pkg.sv
// Shared types and constants for the ball/VGA blocks.
// Holds scheduler state encodings, frame-event defaults and 640x480 timing.
package ball_pkg;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } sched_st_e;

  localparam logic [9:0] TRIG_LINE_DEF = 10'd480;
  localparam logic [9:0] TRIG_COL_DEF  = 10'd0;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = 525;

endpackage

// File: rtl/frame_evt_det.sv
// Frame event detector: fev_o is a combinational one-clk pulse at the
// trigger pixel; frame_tick_o is registered and lasts one pixel period.
module frame_evt_det
  import ball_pkg::*;
#(
  parameter logic [9:0] TRIG_LINE = TRIG_LINE_DEF,
  parameter logic [9:0] TRIG_COL  = TRIG_COL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixpulse_i,
  input  logic [9:0] hcount_i,
  input  logic [9:0] vcount_i,
  output logic       fev_o,
  output logic       frame_tick_o
);

  logic tick_q;

  assign fev_o = pixpulse_i
               & (hcount_i == TRIG_COL)
               & (vcount_i == TRIG_LINE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else if (pixpulse_i) begin
      tick_q <= fev_o;
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/ball_move_sched.sv
// Frame-synchronous move scheduler: one-pixel move strobes to enabled balls
// at a programmable frame rate, with run / pause / single-step control.
// Ports: clk, rst_n, pixpulse, hcount, vcount, run, step, speed, ball_en
// in; move, frame_tick, state, move_count out.
module ball_move_sched
  import ball_pkg::*;
#(
  parameter int         NBALLS    = 4,
  parameter logic [9:0] TRIG_LINE = TRIG_LINE_DEF,
  parameter logic [9:0] TRIG_COL  = TRIG_COL_DEF,
  parameter int         SPD_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixpulse,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              run,
  input  logic              step,
  input  logic [SPD_W-1:0]  speed,
  input  logic [NBALLS-1:0] ball_en,
  output logic [NBALLS-1:0] move,
  output logic              frame_tick,
  output logic [1:0]        state,
  output logic [15:0]       move_count
);

  sched_st_e         state_q, state_d;
  logic [SPD_W-1:0]  div_q, div_d;
  logic [NBALLS-1:0] move_q, move_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              fev;
  logic              issue;
  logic              to_run;

  frame_evt_det #(
    .TRIG_LINE (TRIG_LINE),
    .TRIG_COL  (TRIG_COL)
  ) u_fev (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixpulse_i   (pixpulse),
    .hcount_i     (hcount),
    .vcount_i     (vcount),
    .fev_o        (fev),
    .frame_tick_o (frame_tick)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    move_d  = move_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    issue   = 1'b0;
    to_run  = 1'b0;
    if (pixpulse) begin
      move_d = '0;
      unique case (state_q)
        ST_PRIME: begin
          if (fev) state_d = run ? ST_RUN : ST_PAUSED;
        end
        ST_RUN: begin
          if (!run) begin
            state_d = ST_PAUSED;
          end else if (fev) begin
            // >= lets a lowered speed fire at the very next frame
            if (div_q >= speed) begin
              issue = 1'b1;
              div_d = '0;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (run) begin
            state_d = ST_RUN;
            div_d   = '0;
            to_run  = 1'b1;
          end else if (fev && pend_q) begin
            issue  = 1'b1;
            pend_d = 1'b0;
          end
        end
        default: state_d = ST_PRIME;
      endcase
      if (issue) begin
        move_d = ball_en;
        cnt_d  = cnt_q + 16'd1;
      end
    end
    // step is a one-clk pulse, so it is caught on every clk
    if (state_q == ST_PAUSED && step && !to_run) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_PRIME;
      div_q   <= '0;
      move_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      move_q  <= move_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign move       = move_q;
  assign state      = state_q;
  assign move_count = cnt_q;

endmodule
